// File: rtl/decoder_3to8_sequencer.sv
// rtl/decoder_3to8_sequencer.sv - decodes accepted 3-bit codes into a pending bitmap and replays
// them highest-index-first as one-hot pulses of HOLD_CYCLES with GAP_CYCLES spacing.
module decoder_3to8_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] Y,
    input  logic       V,
    output logic [7:0] D,
    output logic [2:0] A,
    output logic       active,
    output logic [7:0] pending,
    output logic       dup
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    d_n, pend_n;
    logic [2:0]    a_n, k;
    logic          active_n, dup_n, launch;

    // Highest set bit of the pending map; later iterations override earlier ones.
    always_comb begin
        k = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) k = 3'(i);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        d_n      = D;
        a_n      = A;
        active_n = active;
        pend_n   = pending;
        launch   = 1'b0;
        case (state)
            IDLE: begin
                d_n      = 8'h00;
                active_n = 1'b0;
                if (|pending) begin
                    launch    = 1'b1;
                    state_n   = ACTIVE;
                    a_n       = k;
                    d_n       = 8'h01 << k;
                    active_n  = 1'b1;
                    pend_n[k] = 1'b0;
                    cnt_n     = HOLD_LOAD;
                end
            end
            ACTIVE: begin
                if (cnt == '0) begin
                    state_n  = GAP;
                    d_n      = 8'h00;
                    active_n = 1'b0;
                    cnt_n    = GAP_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            default: state_n = IDLE;
        endcase
        // Accept after launch clear so a same-cycle set of k keeps the line pending.
        if (V) pend_n[Y] = 1'b1;
        dup_n = V && pending[Y] && !(launch && (Y == k));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            D       <= 8'h00;
            A       <= 3'd0;
            active  <= 1'b0;
            pending <= 8'h00;
            dup     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            D       <= d_n;
            A       <= a_n;
            active  <= active_n;
            pending <= pend_n;
            dup     <= dup_n;
        end
    end

endmodule

// File: tb/tb_decoder_3to8_sequencer.sv
// tb/tb_decoder_3to8_sequencer.sv - scoreboard bench: stimulus queues expected pulses,
// a negedge monitor pops and checks each pulse as it appears.
module tb_decoder_3to8_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] Y   = 3'd0;
    logic       V   = 1'b0;
    logic [7:0] D;
    logic [2:0] A;
    logic       active;
    logic [7:0] pending;
    logic       dup;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        int len;
    } exp_t;
    exp_t exp_q[$];

    logic mon_on = 1'b0;

    decoder_3to8_sequencer #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .Y(Y), .V(V),
        .D(D), .A(A), .active(active), .pending(pending), .dup(dup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int len);
        exp_t e;
        e.idx = idx;
        e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((active !== 1'b0 || pending !== 8'h00) && n < 200) begin
            step();
            n++;
        end
        chk("idle_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
        step();
        step();
    endtask

    // Monitor: pops one expectation per pulse, checks line, length and spacing.
    initial begin
        int   run, gap, cur_len;
        logic in_pulse, seen_fall;
        run = 0; gap = 0; cur_len = 0;
        in_pulse = 1'b0; seen_fall = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("d_onehot_matches_active", {30'd0, $onehot0(D), (D != 8'h00)},
                    {30'd0, 1'b1, active});
                if (active && !in_pulse) begin
                    in_pulse = 1'b1;
                    run = 1;
                    if (seen_fall) chk("gap_min", (gap >= 2) ? 32'd1 : 32'd0, 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {29'd0, A}, 32'hFFFF_FFFF);
                        cur_len = 4;
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        cur_len = e.len;
                        chk("pulse_line_D", {24'd0, D}, 32'd1 << e.idx);
                        chk("pulse_line_A", {29'd0, A}, e.idx);
                    end
                end else if (active && in_pulse) begin
                    run++;
                end else if (!active && in_pulse) begin
                    in_pulse = 1'b0;
                    seen_fall = 1'b1;
                    gap = 1;
                    chk("pulse_len", run, cur_len);
                end else begin
                    gap++;
                end
            end
        end
    end

    initial begin
        // Reset
        rst = 1'b1; V = 1'b0; Y = 3'd0;
        step(); step();
        rst = 1'b0;
        chk("rst_D", {24'd0, D}, 32'h0);
        chk("rst_A", {29'd0, A}, 32'h0);
        chk("rst_active", {31'd0, active}, 32'h0);
        chk("rst_pending", {24'd0, pending}, 32'h0);
        chk("rst_dup", {31'd0, dup}, 32'h0);
        mon_on = 1'b1;

        // 1 single code
        push(5, 4);
        V = 1'b1; Y = 3'd5; step();
        V = 1'b0;
        chk("t1_pending_c1", {24'd0, pending}, 32'h20);
        chk("t1_active_c1", {31'd0, active}, 32'h0);
        step();
        chk("t1_D_c2", {24'd0, D}, 32'h20);
        chk("t1_pending_c2", {24'd0, pending}, 32'h0);
        step(); step(); step();
        chk("t1_D_c5", {24'd0, D}, 32'h20);
        step();
        chk("t1_D_c6", {24'd0, D}, 32'h0);
        step();
        chk("t1_D_c7", {24'd0, D}, 32'h0);
        wait_idle();

        // 2 ordering while line 2 is active
        push(2, 4);
        V = 1'b1; Y = 3'd2; step();
        V = 1'b0; step();
        chk("t2_line2_active", {24'd0, D}, 32'h04);
        V = 1'b1; Y = 3'd0; step();
        Y = 3'd7; step();
        Y = 3'd3; step();
        V = 1'b0;
        chk("t2_pending", {24'd0, pending}, 32'h89);
        chk("t2_D_held", {24'd0, D}, 32'h04);
        push(7, 4); push(3, 4); push(0, 4);
        wait_idle();

        // 3 duplicate while busy
        push(1, 4); push(4, 4);
        V = 1'b1; Y = 3'd1; step();
        V = 1'b0; step();
        V = 1'b1; Y = 3'd4; step();
        chk("t3_dup_first", {31'd0, dup}, 32'h0);
        chk("t3_pending_first", {24'd0, pending}, 32'h10);
        step();
        chk("t3_dup_second", {31'd0, dup}, 32'h1);
        chk("t3_pending_second", {24'd0, pending}, 32'h10);
        V = 1'b0; step();
        chk("t3_dup_after", {31'd0, dup}, 32'h0);
        wait_idle();

        // 4 accept of 6 on the edge that launches 6
        push(6, 4); push(6, 4);
        V = 1'b1; Y = 3'd6; step();
        chk("t4_pending_c1", {24'd0, pending}, 32'h40);
        step();
        V = 1'b0;
        chk("t4_D_launch", {24'd0, D}, 32'h40);
        chk("t4_dup", {31'd0, dup}, 32'h0);
        chk("t4_pending_kept", {24'd0, pending}, 32'h40);
        wait_idle();

        // 5 reset mid-ACTIVE
        push(5, 2);
        V = 1'b1; Y = 3'd5; step();
        Y = 3'd3; step();
        Y = 3'd2; step();
        chk("t5_pending_c3", {24'd0, pending}, 32'h0C);
        chk("t5_D_c3", {24'd0, D}, 32'h20);
        rst = 1'b1; Y = 3'd1; step();
        rst = 1'b0; V = 1'b0;
        chk("t5_D", {24'd0, D}, 32'h0);
        chk("t5_A", {29'd0, A}, 32'h0);
        chk("t5_active", {31'd0, active}, 32'h0);
        chk("t5_pending", {24'd0, pending}, 32'h0);
        chk("t5_dup", {31'd0, dup}, 32'h0);
        for (int i = 0; i < 8; i++) step();
        chk("t5_still_idle", {24'd0, D | pending}, 32'h0);

        // 6 codes with V low, including X
        for (int i = 0; i < 20; i++) begin
            V = 1'b0;
            Y = ((i % 9) == 8) ? 3'bxxx : 3'(i % 8);
            step();
            chk("t6_pending", {24'd0, pending}, 32'h0);
            chk("t6_D", {24'd0, D}, 32'h0);
            chk("t6_dup", {31'd0, dup}, 32'h0);
        end
        Y = 3'd0;
        step(); step();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
